// File: rtl/cdac_pkg.sv
// Shared types and constants for the CDAC serial receiver.
// Frame layout is {3'b0, CODE[11:0], 1'b0}, shifted MSB first.
package cdac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CODE_W     = 12;
  localparam int PAD_HI_W   = 3;
  localparam int CNT_W      = 5;
  localparam int TMO_W      = 12;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    SHIFT,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_FRAME = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  // Pad bits of a complete frame: three zero MSBs and a zero LSB.
  function automatic logic pad_ok(
    input logic [FRAME_BITS-1:0] sr
  );
    return (sr[FRAME_BITS-1 -: PAD_HI_W] == '0) && !sr[0];
  endfunction

endpackage

// File: rtl/cdac_rx_sync.sv
// Synchronizer chains for the CDAC serial link inputs.
// Also produces the SCLK rise strobe and the CS fall strobe.
module cdac_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_sclk,
  input  logic i_sdata,
  input  logic i_cs,
  input  logic i_ena,
  output logic o_sclk_rise,
  output logic o_sdata_s,
  output logic o_cs_s,
  output logic o_ena_s,
  output logic o_cs_fall
);

  // Bit order in each stage: {sclk, sdata, cs, ena}
  logic [3:0] r_sync [SYNC_STAGES];
  logic       r_sclk_d;
  logic       r_cs_d;
  logic [3:0] w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  // Left unreset so the chain keeps tracking the pins through reset.
  always_ff @(posedge i_clk) begin
    r_sync[0] <= {i_sclk, i_sdata, i_cs, i_ena};
    for (int k = 1; k < SYNC_STAGES; k++)
      r_sync[k] <= r_sync[k-1];
  end

  // One extra delay on synced SCLK and CS for edge detection.
  always_ff @(posedge i_clk) begin
    r_sclk_d <= w_last[3];
    r_cs_d   <= w_last[1];
  end

  assign o_sclk_rise = w_last[3] & ~r_sclk_d;
  assign o_sdata_s   = w_last[2];
  assign o_cs_s      = w_last[1];
  assign o_ena_s     = w_last[0];
  assign o_cs_fall   = ~w_last[1] & r_cs_d;

endmodule

// File: rtl/cdac_serial_rx.sv
// CDAC serial link receiver: oversampled 16-bit deframer.
// Optional CDAC_RX_CMP_EN adds EXP_CODE compare and MISMATCH.
module cdac_serial_rx
  import cdac_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        CLK40,
  input  logic        RST,
  input  logic        SCLK_IN,
  input  logic        SHCK_ENA_IN,
  input  logic        SDATA_IN,
  input  logic        CS_IN,
  input  logic        CLR_ERR,
`ifdef CDAC_RX_CMP_EN
  input  logic [11:0] EXP_CODE,
  output logic        MISMATCH,
`endif
  output logic [11:0] CODE,
  output logic        CODE_VLD,
  output logic        FRAME_ERR,
  output logic [1:0]  ERR_CODE,
  output logic [4:0]  BIT_CNT
);

  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(FRAME_BITS);

  logic w_sclk_rise;
  logic w_sdata_s;
  logic w_cs_s;
  logic w_ena_s;
  logic w_cs_fall;
  logic w_shift;

  logic [FRAME_BITS-1:0] w_sr_nx;
  logic [CNT_W-1:0]      w_cnt_nx;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_sr;
  logic [TMO_W-1:0]      r_tmo;
  logic [1:0]            r_cause;

  cdac_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk      (CLK40),
    .i_sclk     (SCLK_IN),
    .i_sdata    (SDATA_IN),
    .i_cs       (CS_IN),
    .i_ena      (SHCK_ENA_IN),
    .o_sclk_rise(w_sclk_rise),
    .o_sdata_s  (w_sdata_s),
    .o_cs_s     (w_cs_s),
    .o_ena_s    (w_ena_s),
    .o_cs_fall  (w_cs_fall)
  );

  assign w_shift = w_sclk_rise & w_ena_s;

  // Shift result of this cycle, so a CS fall sees the same-cycle bit.
  assign w_sr_nx  = w_shift ? {r_sr[FRAME_BITS-2:0], w_sdata_s} : r_sr;
  assign w_cnt_nx = w_shift ? BIT_CNT + 5'd1 : BIT_CNT;

  // Frame FSM with shift register, counters and registered outputs.
  always_ff @(posedge CLK40) begin
    if (RST) begin
      r_state   <= ARM;
      r_sr      <= '0;
      r_tmo     <= '0;
      r_cause   <= ERR_NONE;
      CODE      <= '0;
      CODE_VLD  <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CODE  <= ERR_NONE;
      BIT_CNT   <= '0;
`ifdef CDAC_RX_CMP_EN
      MISMATCH  <= 1'b0;
`endif
    end else begin
      CODE_VLD <= 1'b0;
      if (CLR_ERR) begin
        FRAME_ERR <= 1'b0;
        ERR_CODE  <= ERR_NONE;
      end
      unique case (r_state)
        ARM: begin
          if (!w_cs_s)
            r_state <= IDLE;
        end
        IDLE: begin
          if (w_cs_s) begin
            r_state <= SHIFT;
            r_sr    <= '0;
            BIT_CNT <= '0;
            r_tmo   <= '0;
          end
        end
        SHIFT: begin
          if (w_shift && BIT_CNT == FULL) begin
            r_cause <= ERR_FRAME;
            r_state <= ERR;
          end else begin
            r_sr    <= w_sr_nx;
            BIT_CNT <= w_cnt_nx;
            r_tmo   <= w_shift ? '0 : r_tmo + 1'b1;
            if (w_cs_fall) begin
              if (w_cnt_nx != FULL) begin
                r_cause <= ERR_SHORT;
                r_state <= ERR;
              end else if (pad_ok(w_sr_nx)) begin
                r_state <= DONE;
              end else begin
                r_cause <= ERR_FRAME;
                r_state <= ERR;
              end
            end else if (!w_shift && r_tmo == TMO_LIM) begin
              r_cause <= ERR_TMO;
              r_state <= ERR;
            end
          end
        end
        DONE: begin
          CODE     <= r_sr[CODE_W:1];
          CODE_VLD <= 1'b1;
`ifdef CDAC_RX_CMP_EN
          MISMATCH <= (r_sr[CODE_W:1] != EXP_CODE);
`endif
          r_state  <= IDLE;
        end
        ERR: begin
          FRAME_ERR <= 1'b1;
          ERR_CODE  <= r_cause;
          r_state   <= ARM;
        end
        default: r_state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_cdac_serial_rx.sv
// Bench for cdac_serial_rx: directed cases plus random frames.
// Expected results come from a frame-level model of the link.
module tb_cdac_serial_rx;

  logic        CLK40 = 1'b0;
  logic        RST = 1'b1;
  logic        SCLK_IN = 1'b0;
  logic        SHCK_ENA_IN = 1'b1;
  logic        SDATA_IN = 1'b0;
  logic        CS_IN = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic [11:0] CODE;
  logic        CODE_VLD;
  logic        FRAME_ERR;
  logic [1:0]  ERR_CODE;
  logic [4:0]  BIT_CNT;
`ifdef CDAC_RX_CMP_EN
  logic [11:0] EXP_CODE = 12'h123;
  logic        MISMATCH;
  logic        exp_mm = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int vld_cnt = 0;

  logic [11:0] exp_code = 12'h000;
  logic        exp_ferr = 1'b0;
  logic [1:0]  exp_errc = 2'd0;

  cdac_serial_rx dut (
    .CLK40      (CLK40),
    .RST        (RST),
    .SCLK_IN    (SCLK_IN),
    .SHCK_ENA_IN(SHCK_ENA_IN),
    .SDATA_IN   (SDATA_IN),
    .CS_IN      (CS_IN),
    .CLR_ERR    (CLR_ERR),
`ifdef CDAC_RX_CMP_EN
    .EXP_CODE   (EXP_CODE),
    .MISMATCH   (MISMATCH),
`endif
    .CODE       (CODE),
    .CODE_VLD   (CODE_VLD),
    .FRAME_ERR  (FRAME_ERR),
    .ERR_CODE   (ERR_CODE),
    .BIT_CNT    (BIT_CNT)
  );

  always #12 CLK40 = ~CLK40;

  always @(negedge CLK40)
    if (CODE_VLD) vld_cnt++;

  initial begin
    #5000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic d, input logic ena);
    SCLK_IN = 1'b0;
    SDATA_IN = d;
    SHCK_ENA_IN = ena;
    #500;
    SCLK_IN = 1'b1;
    #500;
  endtask

  task automatic send_bits(input logic [15:0] w,
                           input int lo, input int hi,
                           input bit noise);
    for (int i = lo; i < hi; i++) begin
      bit_out(i < 16 ? w[15-i] : 1'($urandom), 1'b1);
      if (noise && i == lo + 2)
        bit_out(1'($urandom), 1'b0);
    end
  endtask

  task automatic cs_up;
    SCLK_IN = 1'b0;
    CS_IN = 1'b1;
    #1000;
  endtask

  task automatic cs_down;
    SCLK_IN = 1'b0;
    SHCK_ENA_IN = 1'b1;
    #500;
    CS_IN = 1'b0;
    #1000;
  endtask

  // Frame-level reference: outcome from bit count and pad bits.
  task automatic model(input logic [15:0] w, input int n,
                       output bit good);
    good = 0;
    if (n > 16) begin
      exp_ferr = 1'b1;
      exp_errc = 2'd2;
    end else if (n < 16) begin
      exp_ferr = 1'b1;
      exp_errc = 2'd1;
    end else if (w[15:13] != 3'b000 || w[0]) begin
      exp_ferr = 1'b1;
      exp_errc = 2'd2;
    end else begin
      good = 1;
      exp_code = w[12:1];
`ifdef CDAC_RX_CMP_EN
      exp_mm = (w[12:1] != EXP_CODE);
`endif
    end
  endtask

  task automatic check_out(input string tag, input int v0,
                           input bit good, input int n);
    chk({tag, "_code"}, 32'(CODE), 32'(exp_code));
    chk({tag, "_vld"}, 32'(vld_cnt - v0), good ? 32'd1 : 32'd0);
    chk({tag, "_ferr"}, 32'(FRAME_ERR), 32'(exp_ferr));
    chk({tag, "_errc"}, 32'(ERR_CODE), 32'(exp_errc));
    if (n <= 16)
      chk({tag, "_bcnt"}, 32'(BIT_CNT), 32'(n));
`ifdef CDAC_RX_CMP_EN
    chk({tag, "_mm"}, 32'(MISMATCH), 32'(exp_mm));
`endif
  endtask

  task automatic run_frame(input string tag, input logic [15:0] w,
                           input int n, input bit noise);
    int v0;
    bit good;
    v0 = vld_cnt;
    cs_up();
    send_bits(w, 0, n, noise);
    cs_down();
    model(w, n, good);
    check_out(tag, v0, good, n);
  endtask

  task automatic clear_err;
    @(negedge CLK40);
    CLR_ERR = 1'b1;
    @(negedge CLK40);
    CLR_ERR = 1'b0;
    @(negedge CLK40);
    exp_ferr = 1'b0;
    exp_errc = 2'd0;
    chk("clr_ferr", 32'(FRAME_ERR), 32'd0);
    chk("clr_errc", 32'(ERR_CODE), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_code"}, 32'(CODE), 32'd0);
    chk({tag, "_vld"}, 32'(CODE_VLD), 32'd0);
    chk({tag, "_ferr"}, 32'(FRAME_ERR), 32'd0);
    chk({tag, "_errc"}, 32'(ERR_CODE), 32'd0);
    chk({tag, "_bcnt"}, 32'(BIT_CNT), 32'd0);
  endtask

  function automatic logic [15:0] fr(input logic [11:0] c);
    return {3'b000, c, 1'b0};
  endfunction

  initial begin
    int v0;
    bit good;
    int r;
    int n;
    logic [15:0] w;

    repeat (6) @(negedge CLK40);
    RST = 1'b0;
    @(negedge CLK40);
    check_reset("rst");

    run_frame("good_a5c", fr(12'hA5C), 16, 0);
    run_frame("short10", fr(12'h3C3), 10, 0);
    clear_err();

    run_frame("ovr17", fr(12'h777), 17, 0);
    run_frame("good_001", fr(12'h001), 16, 1);
    clear_err();

    // CS held high with SCLK stopped until the timeout fires.
    v0 = vld_cnt;
    cs_up();
    repeat (4200) @(negedge CLK40);
    chk("tmo_errc", 32'(ERR_CODE), 32'd3);
    chk("tmo_ferr", 32'(FRAME_ERR), 32'd1);
    chk("tmo_vld", 32'(vld_cnt - v0), 32'd0);
    exp_ferr = 1'b1;
    exp_errc = 2'd3;
    cs_down();
    run_frame("after_tmo", fr(12'h5A5), 16, 0);

    // Reset mid-frame: the interrupted frame must be dropped.
    cs_up();
    send_bits(fr(12'h6B2), 0, 8, 0);
    @(negedge CLK40);
    RST = 1'b1;
    repeat (3) @(negedge CLK40);
    RST = 1'b0;
    @(negedge CLK40);
    check_reset("midrst");
    exp_code = 12'h000;
    exp_ferr = 1'b0;
    exp_errc = 2'd0;
`ifdef CDAC_RX_CMP_EN
    exp_mm = 1'b0;
`endif
    v0 = vld_cnt;
    send_bits(fr(12'h6B2), 8, 16, 0);
    cs_down();
    chk("drop_code", 32'(CODE), 32'd0);
    chk("drop_vld", 32'(vld_cnt - v0), 32'd0);
    chk("drop_ferr", 32'(FRAME_ERR), 32'd0);
    run_frame("good_fff", fr(12'hFFF), 16, 0);

`ifdef CDAC_RX_CMP_EN
    run_frame("cmp_124", fr(12'h124), 16, 0);
    chk("cmp_mm1", 32'(MISMATCH), 32'd1);
    run_frame("cmp_123", fr(12'h123), 16, 0);
    chk("cmp_mm0", 32'(MISMATCH), 32'd0);
`endif

    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0)
        clear_err();
      r = $urandom_range(0, 9);
      w = fr(12'($urandom));
      n = 16;
      if (r == 0) n = $urandom_range(0, 15);
      if (r == 1) n = 17;
      if (r == 2) w[15:13] = 3'($urandom_range(1, 7));
      if (r == 3) w[0] = 1'b1;
      run_frame("rnd", w, n, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
